// File: rtl/rf_alu_seq.sv
// ---------------------------------------------------------------------------
// rf_alu_seq
//
// Sequencer that executes one register-file ALU command at a time against an
// external single-port register file with a one-cycle registered read.
//
// ALU commands (ADD/SUB/AND) walk IDLE -> RD1 -> RD2 -> CAP -> WB -> IDLE:
//   RD1 presents rs1, RD2 presents rs2 and captures A, CAP captures B,
//   WB writes the result to rd. LOADI goes straight IDLE -> WB.
//
// Parameters
//   DW : operand / immediate / RF data width
//   AW : RF address width
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                00 ADD, 01 SUB, 10 AND, 11 LOADI
//   cmd_rd/rs1/rs2        destination / source register indices
//   cmd_imm               immediate for LOADI
//   rf_wen/rf_ren         RF write enable / read request
//   rf_addr, rf_wdata     RF address and write data
//   rf_rdata              RF read data, valid one cycle after a read address
//   done                  one-cycle pulse during the write-back cycle
//   result                last written-back value
// ---------------------------------------------------------------------------
module rf_alu_seq #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic          rf_wen,
    output logic          rf_ren,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic          done,
    output logic [DW-1:0] result
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        CAP  = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_LOADI = 2'b11;

    state_t        state_q,  state_d;
    logic [1:0]    op_q,     op_d;
    logic [AW-1:0] rd_q,     rd_d;
    logic [AW-1:0] rs1_q,    rs1_d;
    logic [AW-1:0] rs2_q,    rs2_d;
    logic [DW-1:0] imm_q,    imm_d;
    logic [DW-1:0] opa_q,    opa_d;
    logic [DW-1:0] opb_q,    opb_d;
    logic [DW-1:0] result_q, result_d;

    logic [DW-1:0] alu_val;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Result of the latched command. Only meaningful in WB; operands are
    // the registered copies, so the value is stable for the whole cycle.
    // ------------------------------------------------------------------
    always_comb begin
        alu_val = '0;
        case (op_q)
            OP_ADD:   alu_val = opa_q + opb_q;
            OP_SUB:   alu_val = opa_q - opb_q;
            OP_AND:   alu_val = opa_q & opb_q;
            OP_LOADI: alu_val = imm_q;
            default:  alu_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                // cmd_ready is high only here, so cmd_valid alone is the
                // handshake condition in this state.
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rs1_d   = cmd_rs1;
                    rs2_d   = cmd_rs2;
                    imm_d   = cmd_imm;
                    state_d = (cmd_op == OP_LOADI) ? WB : RD1;
                end
            end
            RD1: begin
                state_d = RD2;
            end
            RD2: begin
                // Data for the rs1 address presented in RD1 arrives now.
                opa_d   = rf_rdata;
                state_d = CAP;
            end
            CAP: begin
                // Data for the rs2 address presented in RD2 arrives now.
                opb_d   = rf_rdata;
                state_d = WB;
            end
            WB: begin
                result_d = alu_val;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state. Both reads finish before the
    // write in WB, so rd aliasing rs1/rs2 needs no special handling.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rf_wen    = 1'b0;
        rf_ren    = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            RD1: begin
                rf_ren  = 1'b1;
                rf_addr = rs1_q;
            end
            RD2: begin
                rf_ren  = 1'b1;
                rf_addr = rs2_q;
            end
            CAP: begin
                // Idle RF cycle: only waiting for the rs2 read data.
            end
            WB: begin
                rf_wen   = 1'b1;
                rf_addr  = rd_q;
                rf_wdata = alu_val;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: doc/rf_alu_seq.md
RF_ALU_SEQ -- requirements
Module: rf_alu_seq

Interface
REQ-001 SHALL have parameter DW, default 32: data width of operands, immediate and RF data.
REQ-002 SHALL have parameter AW, default 2: RF address width (4 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 LOADI.
REQ-008 SHALL have port cmd_rd, cmd_rs1, cmd_rs2  input  AW each  destination and source register indices.
REQ-009 SHALL have port cmd_imm  input  DW  immediate, used only by LOADI.
REQ-010 SHALL have port rf_wen  output  1  RF write enable; 0 means the RF performs a read.
REQ-011 SHALL have port rf_ren  output  1  RF read request.
REQ-012 SHALL have port rf_addr  output  AW  RF address.
REQ-013 SHALL have port rf_wdata  output  DW  RF write data.
REQ-014 SHALL have port rf_rdata  input  DW  RF read data, valid one cycle after the address is presented with rf_wen=0.
REQ-015 SHALL have port done  output  1  one-cycle pulse, write-back performed.
REQ-016 SHALL have port result  output  DW  last written-back value, held until the next write-back.

Function
REQ-017 SHALL implement FSM states IDLE, RD1, RD2, CAP, WB.
REQ-018 SHALL assert cmd_ready only in IDLE; a handshake is cmd_valid=1 and cmd_ready=1 at a rising edge.
REQ-019 SHALL latch op, rd, rs1, rs2 and imm on handshake; later input changes have no effect on the command.
REQ-020 SHALL transition on handshake from IDLE to RD1 for ADD/SUB/AND and from IDLE to WB for LOADI.
REQ-021 SHALL, in RD1, drive rf_addr=rs1, rf_ren=1, rf_wen=0, then go to RD2.
REQ-022 SHALL, in RD2, drive rf_addr=rs2, rf_ren=1, rf_wen=0, capture operand A from rf_rdata at the cycle end, then go to CAP.
REQ-023 SHALL, in CAP, drive rf_ren=0, rf_wen=0, capture operand B from rf_rdata at the cycle end, then go to WB.
REQ-024 SHALL, in WB, drive rf_wen=1, rf_addr=rd, rf_wdata=computed value, done=1, update result at the cycle end, then return to IDLE.
REQ-025 SHALL compute ADD as A+B mod 2^DW, SUB as A-B mod 2^DW (two's complement wrap, no flags), AND as bitwise A&B, and LOADI as imm.
REQ-026 SHALL, outside WB, hold rf_wen=0, rf_wdata=0 and done=0; in IDLE it SHALL hold rf_ren=0 and rf_addr=0.
REQ-027 SHALL give latency from handshake edge to WB cycle of 4 cycles for ALU ops and 1 cycle for LOADI; throughput is one command per 5 cycles (ALU) or 2 cycles (LOADI).
REQ-028 SHALL handle rd equal to rs1 or rs2 correctly: both reads complete before the write.
REQ-029 SHALL ignore cmd_valid while not in IDLE and accept no command in the WB cycle.
REQ-030 SHALL perform at most one RF write per command and never write in any state other than WB.

Reset
REQ-031 SHALL, while rst=1, force state IDLE, cmd_ready=1, rf_wen=0, rf_ren=0, rf_addr=0, rf_wdata=0, done=0, result=0 and the operand registers to 0, asynchronously.
REQ-032 SHALL, on reset asserted mid-command (any state including WB), abandon the command with no write after reset deasserts, and accept a new command in the first cycle after deassertion.

Verification
REQ-033 SHALL test ADD: RF model r1=5, r2=4; cmd ADD rd=3 rs1=1 rs2=2 -> rf_addr sequence 1,2,-,3; write 9 to r3 in cycle 4; done=1 for one cycle; result=9.
REQ-034 SHALL test SUB wrap: r1=5, r2=4; SUB rd=3 rs1=2 rs2=1 -> write 0xFFFFFFFF to r3.
REQ-035 SHALL test LOADI: rd=3 imm=0xDEADBEEF -> rf_wen=1, rf_addr=3 in cycle 1 with no rf_ren pulse; result=0xDEADBEEF.
REQ-036 SHALL test hazard: r3=7, r2=4; AND rd=3 rs1=3 rs2=2 -> write 4 to r3; a following ADD rd=0 rs1=3 rs2=3 -> write 8 to r0.
REQ-037 SHALL test backpressure: cmd_valid held high for 10 cycles with changing fields -> exactly two ALU commands accepted (edges 0 and 5), each using the fields present at its own handshake.
REQ-038 SHALL test reset mid-op: assert rst in CAP -> rf_wen never asserted, all outputs at reset values, new LOADI accepted in the first cycle after rst deasserts.
